fetch_pc_unit: RTL and testbench

Instruction-fetch front end of the single-issue MIPS core. It owns the program counter, computes PC+4, issues word reads to instruction memory (one-cycle read latency) and buffers the returned instructions in a small queue. The queue feeds decode through a valid/ready handshake. Branch, jump and jr redirects from execute flush in-flight work and restart fetch at the target.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_pc_unit_if.sv | 28 ++
 rtl/fetch_queue.sv | 55 +++++
 rtl/fetch_pc_unit.sv | 85 ++++++++
 tb/tb_fetch_pc_unit.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INST_W  = 32;
  localparam int unsigned PC_STEP = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc4;
  } fetch_entry_t;

  // Sequential successor of a PC; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pc_plus_step(input logic [XLEN-1:0] pc);
    return pc + XLEN'(PC_STEP);
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory read port and decode-facing instruction stream.
interface fetch_pc_unit_if;
  import fetch_pkg::*;

  logic              imem_req;
  logic [XLEN-1:0]   imem_addr;
  logic [INST_W-1:0] imem_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst;
  logic [XLEN-1:0]   inst_pc;
  logic [XLEN-1:0]   inst_pc4;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata,
    output inst_valid, inst, inst_pc, inst_pc4,
    input  inst_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata,
    input  inst_valid, inst, inst_pc, inst_pc4,
    output inst_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Small circular FIFO of fetched instructions; flush wins over push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage is reset so the head outputs read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch front end: PC register, credit-based imem requests, redirect flush
// and the sticky misaligned-target flag.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned     QDEPTH   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  fetch_pc_unit_if.master  bus,
  output logic             misalign_err
);

  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
  localparam int unsigned CR_W  = CNT_W + 1;

  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  pc4;
  logic [XLEN-1:0]  req_pc;
  logic             inflight;
  logic             req;
  logic             pop;
  logic [CNT_W-1:0] count;
  logic [CR_W-1:0]  used;
  logic [CR_W-1:0]  avail;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;

  assign pc4 = pc_plus_step(pc);
  assign pop = bus.inst_valid & bus.inst_ready;

  // credits > 0  <=>  count + inflight < QDEPTH + pop
  assign used  = CR_W'(count) + CR_W'(inflight);
  assign avail = CR_W'(QDEPTH) + CR_W'(pop);
  assign req   = rst_n & ~redirect_valid & (used < avail);

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      req_pc       <= '0;
      inflight     <= 1'b0;
      misalign_err <= 1'b0;
    end else if (redirect_valid) begin
      pc       <= {redirect_pc[XLEN-1:2], 2'b00};
      inflight <= 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_err <= 1'b1;
      end
    end else begin
      inflight <= req;
      if (req) begin
        pc     <= pc4;
        req_pc <= pc;
      end
    end
  end

  // A response landing in a redirect cycle is discarded by the queue flush.
  assign push_entry = '{inst: bus.imem_rdata, pc: req_pc, pc4: pc_plus_step(req_pc)};

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (inflight),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign bus.inst_valid = (count != '0);
  assign bus.inst       = head.inst;
  assign bus.inst_pc    = head.pc;
  assign bus.inst_pc4   = head.pc4;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: two instances (default and wrapping RESET_PC).
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign_err;
  logic        redirect_valid2;
  logic [31:0] redirect_pc2;
  logic        misalign_err2;

  int checks = 0;
  int errors = 0;

  fetch_pc_unit_if bus  ();
  fetch_pc_unit_if bus2 ();

  fetch_pc_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
    .misalign_err   (misalign_err)
  );

  fetch_pc_unit #(
    .RESET_PC (32'hFFFF_FFF8),
    .QDEPTH   (2)
  ) dut2 (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid2),
    .redirect_pc    (redirect_pc2),
    .bus            (bus2),
    .misalign_err   (misalign_err2)
  );

  always #5 clk = ~clk;

  // Instruction memory: one-cycle latency, data = addr ^ A5A5_0000
  always @(posedge clk) begin
    if (bus.imem_req)  bus.imem_rdata  <= bus.imem_addr ^ 32'hA5A5_0000;
    if (bus2.imem_req) bus2.imem_rdata <= bus2.imem_addr ^ 32'hA5A5_0000;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic release_reset();
    #3;
    rst_n = 1'b1;
    #1;
  endtask

  // Called in cycle 0 with inst_ready high on both instances.
  task automatic restart_seq();
    logic [31:0] e2pc  [4];
    logic [31:0] e2pc4 [4];
    logic [31:0] e1pc  [4];
    e1pc  = '{32'h0000_0000, 32'h0000_0004, 32'h0000_0008, 32'h0000_000C};
    e2pc  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    e2pc4 = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
    check("c0_req",   32'(bus.imem_req), 32'd1);
    check("c0_addr",  bus.imem_addr, 32'h0);
    check("c0_addr2", bus2.imem_addr, 32'hFFFF_FFF8);
    next(); #1;
    check("c1_valid", 32'(bus.inst_valid), 32'd0);
    check("c1_req",   32'(bus.imem_req), 32'd1);
    check("c1_addr",  bus.imem_addr, 32'h4);
    for (int k = 0; k < 4; k++) begin
      next(); #1;
      check("seq_valid", 32'(bus.inst_valid), 32'd1);
      check("seq_pc",    bus.inst_pc, e1pc[k]);
      check("seq_pc4",   bus.inst_pc4, e1pc[k] + 32'd4);
      check("seq_inst",  bus.inst, e1pc[k] ^ 32'hA5A5_0000);
      check("wrap_valid", 32'(bus2.inst_valid), 32'd1);
      check("wrap_pc",    bus2.inst_pc, e2pc[k]);
      check("wrap_pc4",   bus2.inst_pc4, e2pc4[k]);
      check("wrap_inst",  bus2.inst, e2pc[k] ^ 32'hA5A5_0000);
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    redirect_valid2 = 1'b0;
    redirect_pc2    = '0;
    bus.inst_ready  = 1'b1;
    bus2.inst_ready = 1'b1;
    #1;
    check("rst_req",   32'(bus.imem_req), 32'd0);
    check("rst_valid", 32'(bus.inst_valid), 32'd0);
    check("rst_mis",   32'(misalign_err), 32'd0);
    check("rst_inst",  bus.inst, 32'h0);
    check("rst_pc",    bus.inst_pc, 32'h0);
    check("rst_pc4",   bus.inst_pc4, 32'h0);

    // Free-running fetch out of reset
    next();
    release_reset();
    restart_seq();

    // Backpressure: inst_ready low for cycles 2..6
    next();
    rst_n = 1'b0;
    bus.inst_ready = 1'b0;
    next();
    release_reset();
    check("bp_c0_addr", bus.imem_addr, 32'h0);
    next(); #1;
    check("bp_c1_req",  32'(bus.imem_req), 32'd1);
    check("bp_c1_addr", bus.imem_addr, 32'h4);
    for (int c = 2; c <= 6; c++) begin
      next(); #1;
      check("bp_stall_req",   32'(bus.imem_req), 32'd0);
      check("bp_stall_valid", 32'(bus.inst_valid), 32'd1);
      check("bp_stall_pc",    bus.inst_pc, 32'h0);
    end
    next();
    bus.inst_ready = 1'b1;
    #1;
    check("bp_rel_req",  32'(bus.imem_req), 32'd1);
    check("bp_rel_addr", bus.imem_addr, 32'h8);
    check("bp_rel_pc",   bus.inst_pc, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      next(); #1;
      check("bp_drain_valid", 32'(bus.inst_valid), 32'd1);
      check("bp_drain_pc",    bus.inst_pc, 32'(k * 4));
    end

    // Redirect to 0x100 with a response in flight and the head being popped
    next();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    #1;
    check("rd_req_blocked", 32'(bus.imem_req), 32'd0);
    check("rd_head_valid",  32'(bus.inst_valid), 32'd1);
    next();
    redirect_valid = 1'b0;
    #1;
    check("rd_t1_valid", 32'(bus.inst_valid), 32'd0);
    check("rd_t1_req",   32'(bus.imem_req), 32'd1);
    check("rd_t1_addr",  bus.imem_addr, 32'h100);
    next(); #1;
    check("rd_t2_valid", 32'(bus.inst_valid), 32'd0);
    next(); #1;
    check("rd_t3_valid", 32'(bus.inst_valid), 32'd1);
    check("rd_t3_pc",    bus.inst_pc, 32'h100);
    check("rd_t3_pc4",   bus.inst_pc4, 32'h104);
    check("rd_t3_inst",  bus.inst, 32'hA5A5_0100);
    next(); #1;
    check("rd_t4_pc",    bus.inst_pc, 32'h104);
    check("rd_mis_clear", 32'(misalign_err), 32'd0);

    // Misaligned redirect target
    next();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    #1;
    check("mis_req_blocked", 32'(bus.imem_req), 32'd0);
    check("mis_before",      32'(misalign_err), 32'd0);
    next();
    redirect_valid = 1'b0;
    #1;
    check("mis_set",  32'(misalign_err), 32'd1);
    check("mis_addr", bus.imem_addr, 32'h100);
    next();
    next(); #1;
    check("mis_pc",    bus.inst_pc, 32'h100);
    check("mis_valid", 32'(bus.inst_valid), 32'd1);

    // Back-to-back redirects: last target wins
    next();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    #1;
    check("b2b_req0", 32'(bus.imem_req), 32'd0);
    next();
    redirect_pc = 32'h0000_0300;
    #1;
    check("b2b_req1", 32'(bus.imem_req), 32'd0);
    next();
    redirect_valid = 1'b0;
    #1;
    check("b2b_addr",   bus.imem_addr, 32'h300);
    check("b2b_req2",   32'(bus.imem_req), 32'd1);
    check("b2b_valid0", 32'(bus.inst_valid), 32'd0);
    next(); #1;
    check("b2b_valid1", 32'(bus.inst_valid), 32'd0);
    next(); #1;
    check("b2b_pc",     bus.inst_pc, 32'h300);
    check("b2b_sticky", 32'(misalign_err), 32'd1);

    // Fill the queue, then async reset mid-cycle
    next();
    bus.inst_ready = 1'b0;
    next();
    next();
    next(); #1;
    check("full_valid", 32'(bus.inst_valid), 32'd1);
    check("full_req",   32'(bus.imem_req), 32'd0);
    check("full_pc",    bus.inst_pc, 32'h304);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.inst_valid), 32'd0);
    check("arst_req",   32'(bus.imem_req), 32'd0);
    check("arst_mis",   32'(misalign_err), 32'd0);
    check("arst_pc",    bus.inst_pc, 32'h0);
    check("arst_inst",  bus.inst, 32'h0);
    next();
    bus.inst_ready = 1'b1;
    release_reset();
    restart_seq();

    check("wrap_mis", 32'(misalign_err2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
